capture_sequencer: RTL



---
 rtl/cam_seq_pkg.sv | 27 ++
 rtl/seq_timer.sv | 28 ++
 rtl/capture_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cam_seq_pkg.sv
// Shared types for the capture sequencer: state encoding, default widths and
// the host command record.
package cam_seq_pkg;

    localparam int CAM_CNT_W = 16;
    localparam int CAM_TMR_W = 32;

    // Index of each timer in the sequencer's timer bank.
    localparam int TMR_INTERVAL = 0;
    localparam int TMR_TIMEOUT  = 1;
    localparam int NUM_TMR      = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_END,
        GAP,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [CAM_CNT_W-1:0] frames;
        logic [CAM_TMR_W-1:0] interval;
        logic [CAM_TMR_W-1:0] timeout;
    } cam_cmd_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that saturates at zero; zero_next flags the last
// counted cycle (the count will be zero once this cycle ends).
module seq_timer #(
    parameter int TMR_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero_next
);

    logic [TMR_W-1:0] count_reg;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - TMR_W'(1);
        end
    end

    assign zero_next = (count_reg <= TMR_W'(1));

endmodule

// File: rtl/capture_sequencer.sv
// Runs one host capture command: pulses capture, waits for each capture_end
// rise, spaces pulses by the interval and aborts the run on a per-frame timeout.
module capture_sequencer
    import cam_seq_pkg::*;
#(
    parameter int CNT_W = CAM_CNT_W,
    parameter int TMR_W = CAM_TMR_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_frames,
    input  logic [TMR_W-1:0] cmd_interval,
    input  logic [TMR_W-1:0] cmd_timeout,
    input  logic             abort,
    output logic             capture,
    input  logic             capture_end,
    output logic             busy,
    output logic [CNT_W-1:0] frames_done,
    output logic             seq_done,
    output logic             seq_abort,
    output logic             err_timeout
);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] frames_reg;
    logic [TMR_W-1:0] interval_reg;
    logic [TMR_W-1:0] timeout_reg;
    logic [CNT_W-1:0] frames_done_reg, frames_done_next;
    logic             err_timeout_reg, err_timeout_next;
    logic             seq_abort_reg, seq_abort_next;
    logic             capture_end_q;
    logic             accept;
    logic             end_evt;

    logic [TMR_W-1:0]   tmr_load_val [NUM_TMR];
    logic [NUM_TMR-1:0] tmr_zero_next;

    assign accept  = cmd_valid && (state_reg == IDLE);
    assign end_evt = capture_end && !capture_end_q;

    // The ARM cycle is itself the first cycle of the start-to-start interval.
    assign tmr_load_val[TMR_INTERVAL] = (interval_reg == '0) ? '0 : interval_reg - TMR_W'(1);
    assign tmr_load_val[TMR_TIMEOUT]  = timeout_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TMR; gi++) begin : g_tmr
            seq_timer #(
                .TMR_W(TMR_W)
            ) u_tmr (
                .sys_clk  (sys_clk),
                .sys_rst_n(sys_rst_n),
                .load     (state_reg == ARM),
                .load_val (tmr_load_val[gi]),
                .en       (state_reg != IDLE),
                .zero_next(tmr_zero_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            frames_reg      <= '0;
            interval_reg    <= '0;
            timeout_reg     <= '0;
            frames_done_reg <= '0;
            err_timeout_reg <= 1'b0;
            seq_abort_reg   <= 1'b0;
            capture_end_q   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frames_done_reg <= frames_done_next;
            err_timeout_reg <= err_timeout_next;
            seq_abort_reg   <= seq_abort_next;
            capture_end_q   <= capture_end;
            if (accept) begin
                frames_reg   <= cmd_frames;
                interval_reg <= cmd_interval;
                timeout_reg  <= cmd_timeout;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        frames_done_next = frames_done_reg;
        err_timeout_next = err_timeout_reg;
        seq_abort_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next       = ARM;
                    frames_done_next = '0;
                    err_timeout_next = 1'b0;
                end
            end
            ARM: state_next = WAIT_END;
            WAIT_END: begin
                if (end_evt) begin
                    frames_done_next = frames_done_reg + CNT_W'(1);
                    if (frames_reg != '0 && frames_done_next == frames_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = GAP;
                    end
                end else if (timeout_reg != '0 && tmr_zero_next[TMR_TIMEOUT]) begin
                    err_timeout_next = 1'b1;
                    state_next       = IDLE;
                end
            end
            GAP: begin
                if (tmr_zero_next[TMR_INTERVAL]) begin
                    state_next = ARM;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides everything except counting a frame that ended this cycle.
        if (abort && state_reg != IDLE) begin
            state_next       = IDLE;
            seq_abort_next   = 1'b1;
            err_timeout_next = err_timeout_reg;
        end
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign capture     = (state_reg == ARM);
    assign seq_done    = (state_reg == DONE);
    assign seq_abort   = seq_abort_reg;
    assign err_timeout = err_timeout_reg;
    assign frames_done = frames_done_reg;

endmodule
